rate_divider_mc: RTL

- Multi-channel, run-time programmable successor to the single-channel 5 kHz rate divider.
- Each of NUM_CH channels divides a shared tick stream by its own CNT_W-bit divisor. Each channel emits a registered one-cycle pulse every DIV qualified ticks.
- Divisors load through a valid/ready config port and take effect glitch-free at the channel's terminal count.
- Sits beside the 5 kHz clock source and feeds flash/blink and display-refresh logic.

---
 rtl/rate_div_pkg.sv | 17 +
 rtl/rate_div_chan.sv | 116 +++++++++++
 rtl/rate_divider_mc.sv | 67 ++++++
 3 files changed

// File: rtl/rate_div_pkg.sv
// rate_div_pkg -- shared constants and types for the multi-channel rate divider.
//   CNT_W_DEF : default divisor/counter width
//   div_t     : divisor type at the default width
//   DIV_*     : legacy rates against the 5 kHz tick (DIV_OFF stops a channel)
package rate_div_pkg;

    localparam int CNT_W_DEF = 28;

    typedef logic [CNT_W_DEF-1:0] div_t;

    localparam div_t DIV_OFF    = '0;
    localparam div_t DIV_FULL   = div_t'(1);
    localparam div_t DIV_1HZ    = div_t'(5000);
    localparam div_t DIV_0P5HZ  = div_t'(10000);
    localparam div_t DIV_0P25HZ = div_t'(20000);

endpackage

// File: rtl/rate_div_chan.sv
// rate_div_chan -- one divider channel: counter, active divisor, one-deep
// pending-divisor slot and registered output pulse.
//   i_clock / i_resetn : clock, async active-low reset
//   i_tick_en          : counter advances only when 1
//   i_sync_clr         : reload counter (applying any pending divisor)
//   i_acc / i_acc_div  : accepted config write for this channel
//   o_pending          : pending slot occupied (config not ready)
//   o_pulse            : one-cycle pulse, the cycle after the terminal tick
//   o_square           : RATE_DIV_TOGGLE_EN only; toggles with each pulse
module rate_div_chan
    import rate_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = int'(DIV_1HZ)
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_tick_en,
    input  logic             i_sync_clr,
    input  logic             i_acc,
    input  logic [CNT_W-1:0] i_acc_div,
    output logic             o_pending,
    output logic             o_pulse
`ifdef RATE_DIV_TOGGLE_EN
    ,
    output logic             o_square
`endif
);

    localparam logic [CNT_W-1:0] DEF_D   = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_CNT = (DEF_DIV == 0) ? '0 : CNT_W'(DEF_DIV - 1);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_pulse;
`ifdef RATE_DIV_TOGGLE_EN
    logic             r_square;
`endif

    // Reload value for a divisor; a zero divisor parks the counter at 0
    // instead of wrapping to all-ones.
    function automatic logic [CNT_W-1:0] f_reload(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] w_sync_div;
    assign w_sync_div = r_pend ? r_pend_div : r_div;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_div      <= DEF_D;
            r_cnt      <= DEF_CNT;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_pulse    <= 1'b0;
`ifdef RATE_DIV_TOGGLE_EN
            r_square   <= 1'b0;
`endif
        end else begin
            r_pulse <= 1'b0;
            if (i_sync_clr) begin
                if (r_pend) begin
                    r_div  <= r_pend_div;
                    r_pend <= 1'b0;
                end
                r_cnt <= f_reload(w_sync_div);
`ifdef RATE_DIV_TOGGLE_EN
                r_square <= 1'b0;
`endif
            end else if (r_div == '0) begin
                // Channel off: a pending divisor restarts it without waiting
                // for a tick.
                r_cnt <= '0;
`ifdef RATE_DIV_TOGGLE_EN
                r_square <= 1'b0;
`endif
                if (r_pend) begin
                    r_div  <= r_pend_div;
                    r_pend <= 1'b0;
                    r_cnt  <= f_reload(r_pend_div);
                end
            end else if (i_tick_en) begin
                if (r_cnt == '0) begin
                    r_pulse <= 1'b1;
`ifdef RATE_DIV_TOGGLE_EN
                    r_square <= ~r_square;
`endif
                    if (r_pend) begin
                        r_div  <= r_pend_div;
                        r_pend <= 1'b0;
                        r_cnt  <= f_reload(r_pend_div);
                    end else begin
                        r_cnt <= r_div - CNT_W'(1);
                    end
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            // Accept only happens while the slot is empty, and every apply
            // path above requires it full, so these never collide.
            if (i_acc) begin
                r_pend_div <= i_acc_div;
                r_pend     <= 1'b1;
            end
        end
    end

    assign o_pending = r_pend;
    assign o_pulse   = r_pulse;
`ifdef RATE_DIV_TOGGLE_EN
    assign o_square  = r_square;
`endif

endmodule

// File: rtl/rate_divider_mc.sv
// rate_divider_mc -- NUM_CH independent programmable dividers of a shared
// tick stream, with a valid/ready divisor config port.
//   i_clock / i_resetn   : clock, async active-low reset
//   i_tick_en            : qualified tick
//   i_sync_clr           : phase-align all channels
//   i_cfg_valid/o_cfg_ready, i_cfg_chan, i_cfg_div : divisor config port
//   o_pulse [NUM_CH]     : per-channel one-cycle pulse
//   o_square [NUM_CH]    : only when RATE_DIV_TOGGLE_EN is defined
module rate_divider_mc
    import rate_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = int'(DIV_1HZ),
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_tick_en,
    input  logic              i_sync_clr,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_chan,
    input  logic [CNT_W-1:0]  i_cfg_div,
    output logic [NUM_CH-1:0] o_pulse
`ifdef RATE_DIV_TOGGLE_EN
    ,
    output logic [NUM_CH-1:0] o_square
`endif
);

    logic [NUM_CH-1:0]    w_pending;
    logic [NUM_CH-1:0]    w_acc;
    logic [2**CH_W-1:0]   w_pend_ext;

    // Unused channel codes read as "not pending": always ready, and the
    // transfer matches no channel so it is simply dropped.
    always_comb begin
        w_pend_ext = '0;
        for (int i = 0; i < NUM_CH; i++) w_pend_ext[i] = w_pending[i];
    end

    assign o_cfg_ready = ~w_pend_ext[i_cfg_chan];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_acc[gi] = i_cfg_valid & o_cfg_ready & (i_cfg_chan == CH_W'(gi));

        rate_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .i_clock    (i_clock),
            .i_resetn   (i_resetn),
            .i_tick_en  (i_tick_en),
            .i_sync_clr (i_sync_clr),
            .i_acc      (w_acc[gi]),
            .i_acc_div  (i_cfg_div),
            .o_pending  (w_pending[gi]),
            .o_pulse    (o_pulse[gi])
`ifdef RATE_DIV_TOGGLE_EN
            ,
            .o_square   (o_square[gi])
`endif
        );
    end

endmodule
